// File: rtl/ones_pkg.sv
// ---------------------------------------------------------------------------
// ones_pkg
// Shared constants and types for the per-frame ones accumulator.
//   ONES_W        : width of one per-byte ones count (0..8 legal, 9..15 illegal)
//   ONES_MAX      : largest legal per-byte ones count
//   CNT_W_DEFAULT : default width of the frame total and beat counter
//   state_e       : frame FSM state (ACCUM collects beats, HOLD presents result)
// ---------------------------------------------------------------------------
package ones_pkg;
   localparam int ONES_W        = 4;
   localparam int ONES_MAX      = 8;
   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;
endpackage : ones_pkg

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Unsigned W-bit adder that clamps at 2^W-1 instead of wrapping.
// Ports:
//   a   : in  W  current value
//   inc : in  W  increment
//   sum : out W  a + inc, clamped to all-ones
//   sat : out 1  the true sum did not fit in W bits
// ---------------------------------------------------------------------------
module sat_add #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] inc,
   output logic [W-1:0] sum,
   output logic         sat
);
   logic [W:0] full_sum;

   always_comb begin
      full_sum = {1'b0, a} + {1'b0, inc};
      sat      = full_sum[W];
      sum      = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];
   end
endmodule : sat_add

// File: rtl/ones_frame_accum.sv
// ---------------------------------------------------------------------------
// ones_frame_accum
// Accumulates per-byte ones counts over a valid/ready beat stream into a
// saturating per-frame total (frames end on in_last) and presents the total,
// beat count and sticky saturation/illegal-count flags on a valid/ready port.
//
// Ports:
//   clk       : in  1      rising-edge clock
//   rst       : in  1      synchronous active-high reset
//   in_ones   : in  4      ones count of one byte (legal 0..8)
//   in_valid  : in  1      beat valid
//   in_last   : in  1      final beat of frame
//   in_ready  : out 1      stage can accept a beat
//   out_total : out CNT_W  frame ones total
//   out_beats : out CNT_W  beats in frame
//   out_sat   : out 1      total or beat count saturated during the frame
//   out_err   : out 1      at least one beat carried in_ones > 8
//   out_valid : out 1      result valid
//   out_ready : in  1      downstream accepts result
//
// Build option: define ONES_FRAME_ACCUM_SKID_EN to keep accepting beats while
// a result is held; only a completed next frame waits for the transfer.
// ---------------------------------------------------------------------------
module ones_frame_accum
   import ones_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ONES_W-1:0] in_ones,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [CNT_W-1:0]  out_total,
   output logic [CNT_W-1:0]  out_beats,
   output logic              out_sat,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready
);
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic              sat_q, sat_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  out_total_q, out_total_d;
   logic [CNT_W-1:0]  out_beats_q, out_beats_d;
   logic              out_sat_q, out_sat_d;
   logic              out_err_q, out_err_d;
`ifdef ONES_FRAME_ACCUM_SKID_EN
   // A completed frame is parked in acc/beats/sticky until the held result leaves.
   logic              pend_q, pend_d;
`endif

   logic              ones_legal;
   logic [ONES_W-1:0] add_ones;
   logic [CNT_W-1:0]  tot_sum, beat_sum;
   logic              tot_sat, beat_sat;
   logic              new_sat, new_err;
   logic              beat_fire;

   // Illegal counts contribute nothing to the total but still count as beats.
   assign ones_legal = (in_ones <= ONES_W'(ONES_MAX));
   assign add_ones   = ones_legal ? in_ones : '0;

   sat_add #(.W(CNT_W)) u_tot_add (
      .a   (acc_q),
      .inc (CNT_W'(add_ones)),
      .sum (tot_sum),
      .sat (tot_sat)
   );

   sat_add #(.W(CNT_W)) u_beat_add (
      .a   (beats_q),
      .inc (CNT_W'(1)),
      .sum (beat_sum),
      .sat (beat_sat)
   );

   assign new_sat = sat_q | tot_sat | beat_sat;
   assign new_err = err_q | ~ones_legal;

`ifdef ONES_FRAME_ACCUM_SKID_EN
   assign in_ready = ~pend_q;
`else
   assign in_ready = (state_q == ACCUM);
`endif
   assign out_valid = (state_q == HOLD);
   assign beat_fire = in_valid & in_ready;

   assign out_total = out_total_q;
   assign out_beats = out_beats_q;
   assign out_sat   = out_sat_q;
   assign out_err   = out_err_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      beats_d     = beats_q;
      sat_d       = sat_q;
      err_d       = err_q;
      out_total_d = out_total_q;
      out_beats_d = out_beats_q;
      out_sat_d   = out_sat_q;
      out_err_d   = out_err_q;
`ifdef ONES_FRAME_ACCUM_SKID_EN
      pend_d      = pend_q;
`endif
      case (state_q)
         ACCUM: begin
            if (beat_fire) begin
               if (in_last) begin
                  out_total_d = tot_sum;
                  out_beats_d = beat_sum;
                  out_sat_d   = new_sat;
                  out_err_d   = new_err;
                  acc_d       = '0;
                  beats_d     = '0;
                  sat_d       = 1'b0;
                  err_d       = 1'b0;
                  state_d     = HOLD;
               end else begin
                  acc_d       = tot_sum;
                  beats_d     = beat_sum;
                  sat_d       = new_sat;
                  err_d       = new_err;
               end
            end
         end
         HOLD: begin
`ifdef ONES_FRAME_ACCUM_SKID_EN
            if (pend_q) begin
               // Parked frame replaces the held one as soon as it is taken.
               if (out_ready) begin
                  out_total_d = acc_q;
                  out_beats_d = beats_q;
                  out_sat_d   = sat_q;
                  out_err_d   = err_q;
                  acc_d       = '0;
                  beats_d     = '0;
                  sat_d       = 1'b0;
                  err_d       = 1'b0;
                  pend_d      = 1'b0;
               end
            end else if (beat_fire && in_last) begin
               if (out_ready) begin
                  // Back-to-back result: load directly, out_valid stays high.
                  out_total_d = tot_sum;
                  out_beats_d = beat_sum;
                  out_sat_d   = new_sat;
                  out_err_d   = new_err;
                  acc_d       = '0;
                  beats_d     = '0;
                  sat_d       = 1'b0;
                  err_d       = 1'b0;
               end else begin
                  acc_d       = tot_sum;
                  beats_d     = beat_sum;
                  sat_d       = new_sat;
                  err_d       = new_err;
                  pend_d      = 1'b1;
               end
            end else begin
               if (beat_fire) begin
                  acc_d       = tot_sum;
                  beats_d     = beat_sum;
                  sat_d       = new_sat;
                  err_d       = new_err;
               end
               if (out_ready) begin
                  state_d     = ACCUM;
               end
            end
`else
            if (out_ready) begin
               state_d = ACCUM;
            end
`endif
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         beats_q     <= '0;
         sat_q       <= 1'b0;
         err_q       <= 1'b0;
         out_total_q <= '0;
         out_beats_q <= '0;
         out_sat_q   <= 1'b0;
         out_err_q   <= 1'b0;
`ifdef ONES_FRAME_ACCUM_SKID_EN
         pend_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         beats_q     <= beats_d;
         sat_q       <= sat_d;
         err_q       <= err_d;
         out_total_q <= out_total_d;
         out_beats_q <= out_beats_d;
         out_sat_q   <= out_sat_d;
         out_err_q   <= out_err_d;
`ifdef ONES_FRAME_ACCUM_SKID_EN
         pend_q      <= pend_d;
`endif
      end
   end
endmodule : ones_frame_accum
